// File: rtl/dmem_arbiter.sv
// Round-robin two-port arbiter in front of the single-port data RAM.
// Port 0 is the core LSU, port 1 the debug/loader master; responses come back one cycle after acceptance.
module dmem_arbiter #(
  parameter logic [31:0] BASE_ADDR = 32'h0001_0000,
  parameter int          AW        = 13
) (
  input  logic          HCLK,
  input  logic          HRESETn,

  input  logic          p0_req,
  input  logic          p0_we,
  input  logic [31:0]   p0_addr,
  input  logic [3:0]    p0_be,
  input  logic [31:0]   p0_wdata,
  output logic          p0_gnt,
  output logic          p0_rvalid,
  output logic [31:0]   p0_rdata,
  output logic          p0_err,

  input  logic          p1_req,
  input  logic          p1_we,
  input  logic [31:0]   p1_addr,
  input  logic [3:0]    p1_be,
  input  logic [31:0]   p1_wdata,
  output logic          p1_gnt,
  output logic          p1_rvalid,
  output logic [31:0]   p1_rdata,
  output logic          p1_err,

  output logic          ram_cs,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [31:0]   ram_wmask,
  output logic [31:0]   ram_wdata,
  input  logic [31:0]   ram_rdata
);

  localparam logic [32:0] WIN_BYTES = 33'd4 << AW;

  logic        lastWinner_q, lastWinner_d;
  logic        respValid_q, respValid_d;
  logic        respPort_q, respPort_d;
  logic        respErr_q, respErr_d;
  logic        respRead_q, respRead_d;

  logic        anyGnt;
  logic        selWe;
  logic [31:0] selAddr;
  logic [3:0]  selBe;
  logic [31:0] selWdata;
  logic [31:0] selOff;
  logic        selInWin;
  logic        ramAccess;

  // On a tie the port that did not win last time gets the grant; nothing is granted during reset.
  assign p0_gnt = HRESETn & p0_req & (~p1_req | lastWinner_q);
  assign p1_gnt = HRESETn & p1_req & (~p0_req | ~lastWinner_q);
  assign anyGnt = p0_gnt | p1_gnt;

  assign selWe    = p1_gnt ? p1_we    : p0_we;
  assign selAddr  = p1_gnt ? p1_addr  : p0_addr;
  assign selBe    = p1_gnt ? p1_be    : p0_be;
  assign selWdata = p1_gnt ? p1_wdata : p0_wdata;

  // Unsigned wrap makes addresses below the base fail the window check as well.
  assign selOff    = selAddr - BASE_ADDR;
  assign selInWin  = ({1'b0, selOff} < WIN_BYTES);
  assign ramAccess = anyGnt & selInWin & (|selBe);

  always_comb begin
    ram_cs    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wmask = '0;
    ram_wdata = '0;
    if (ramAccess) begin
      ram_cs    = 1'b1;
      ram_we    = selWe;
      ram_addr  = selOff[AW+1:2];
      ram_wmask = {{8{selBe[3]}}, {8{selBe[2]}}, {8{selBe[1]}}, {8{selBe[0]}}};
      ram_wdata = selWdata;
    end
  end

  assign lastWinner_d = anyGnt ? p1_gnt : lastWinner_q;
  assign respValid_d  = anyGnt;
  assign respPort_d   = p1_gnt;
  assign respErr_d    = anyGnt & ~selInWin;
  assign respRead_d   = ramAccess & ~selWe;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      lastWinner_q <= 1'b1;
      respValid_q  <= 1'b0;
      respPort_q   <= 1'b0;
      respErr_q    <= 1'b0;
      respRead_q   <= 1'b0;
    end else begin
      lastWinner_q <= lastWinner_d;
      respValid_q  <= respValid_d;
      respPort_q   <= respPort_d;
      respErr_q    <= respErr_d;
      respRead_q   <= respRead_d;
    end
  end

  // The registered owner steers the RAM's registered read data so responses never cross ports.
  assign p0_rvalid = respValid_q & ~respPort_q;
  assign p1_rvalid = respValid_q & respPort_q;
  assign p0_err    = p0_rvalid & respErr_q;
  assign p1_err    = p1_rvalid & respErr_q;
  assign p0_rdata  = (p0_rvalid & respRead_q) ? ram_rdata : '0;
  assign p1_rdata  = (p1_rvalid & respRead_q) ? ram_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter with a behavioural registered-read RAM model.
// Directed vectors from a table, plus hand-written contention and reset sequences.
module tb_dmem_arbiter;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } portIn_t;

  typedef struct packed {
    portIn_t     p0;
    portIn_t     p1;
    logic        gnt0;
    logic        gnt1;
    logic        cs;
    logic        we;
    logic [12:0] addr;
    logic [31:0] wmask;
    logic [31:0] wdata;
    logic        rvalid0;
    logic        err0;
    logic [31:0] rdata0;
    logic        rvalid1;
    logic        err1;
    logic [31:0] rdata1;
  } vec_t;

  localparam logic [31:0] BASE = 32'h0001_0000;
  localparam int NVEC = 12;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic [3:0]  p0_be, p1_be;
  logic        p0_gnt, p0_rvalid, p0_err, p1_gnt, p1_rvalid, p1_err;
  logic [31:0] p0_rdata, p1_rdata;
  logic        ram_cs, ram_we;
  logic [12:0] ram_addr;
  logic [31:0] ram_wmask, ram_wdata;
  logic [31:0] ram_rdata;
  logic [31:0] mem [8192];

  int checks = 0;
  int errors = 0;
  vec_t vecs [NVEC];
  portIn_t idlePort;

  dmem_arbiter #(.BASE_ADDR(BASE), .AW(13)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_be(p0_be), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata), .p0_err(p0_err),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_be(p1_be), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata), .p1_err(p1_err),
    .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wmask(ram_wmask),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 HCLK = ~HCLK;

  // RAM model: masked synchronous write, registered read data.
  always @(posedge HCLK) begin
    if (ram_cs) begin
      if (ram_we)
        mem[ram_addr] <= (mem[ram_addr] & ~ram_wmask) | (ram_wdata & ram_wmask);
      else
        ram_rdata <= mem[ram_addr];
    end
  end

  function automatic portIn_t mkRd(input logic [31:0] a, input logic [3:0] be);
    mkRd = '{req: 1'b1, we: 1'b0, addr: a, be: be, wdata: 32'h0};
  endfunction

  function automatic portIn_t mkWr(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
    mkWr = '{req: 1'b1, we: 1'b1, addr: a, be: be, wdata: d};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drivePorts(input portIn_t a, input portIn_t b);
    p0_req = a.req; p0_we = a.we; p0_addr = a.addr; p0_be = a.be; p0_wdata = a.wdata;
    p1_req = b.req; p1_we = b.we; p1_addr = b.addr; p1_be = b.be; p1_wdata = b.wdata;
  endtask

  // One vector: request cycle with RAM-side checks, then an idle cycle carrying the response.
  task automatic applyStimulus(input vec_t v, input int idx);
    @(negedge HCLK);
    drivePorts(v.p0, v.p1);
    #1;
    checkOutput($sformatf("v%0d gnt0", idx), 32'(p0_gnt), 32'(v.gnt0));
    checkOutput($sformatf("v%0d gnt1", idx), 32'(p1_gnt), 32'(v.gnt1));
    checkOutput($sformatf("v%0d ram_cs", idx), 32'(ram_cs), 32'(v.cs));
    checkOutput($sformatf("v%0d ram_we", idx), 32'(ram_we), 32'(v.we));
    checkOutput($sformatf("v%0d ram_addr", idx), 32'(ram_addr), 32'(v.addr));
    checkOutput($sformatf("v%0d ram_wmask", idx), ram_wmask, v.wmask);
    checkOutput($sformatf("v%0d ram_wdata", idx), ram_wdata, v.wdata);
    @(negedge HCLK);
    drivePorts(idlePort, idlePort);
    #1;
    checkOutput($sformatf("v%0d rvalid0", idx), 32'(p0_rvalid), 32'(v.rvalid0));
    checkOutput($sformatf("v%0d err0", idx), 32'(p0_err), 32'(v.err0));
    checkOutput($sformatf("v%0d rdata0", idx), p0_rdata, v.rdata0);
    checkOutput($sformatf("v%0d rvalid1", idx), 32'(p1_rvalid), 32'(v.rvalid1));
    checkOutput($sformatf("v%0d err1", idx), 32'(p1_err), 32'(v.err1));
    checkOutput($sformatf("v%0d rdata1", idx), p1_rdata, v.rdata1);
  endtask

  initial begin
    idlePort = '{req: 1'b0, we: 1'b0, addr: 32'h0, be: 4'h0, wdata: 32'h0};
    for (int i = 0; i < 8192; i++) mem[i] = 32'h0;
    mem[2]    = 32'h1122_3344;
    mem[3]    = 32'hDEAD_BEEF;
    mem[8191] = 32'hCAFE_F00D;
    ram_rdata = 32'h0;

    //          p0                                   p1                                  g0    g1    cs    we    addr        wmask          wdata          rv0   e0    rd0            rv1   e1    rd1
    vecs[0]  = '{mkRd(BASE+32'hC, 4'hF),            idlePort,                           1'b1, 1'b0, 1'b1, 1'b0, 13'd3,    32'hFFFFFFFF, 32'h0,        1'b1, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0};
    vecs[1]  = '{idlePort,                           mkWr(BASE+32'h8, 4'b0100, 32'h00AB0000), 1'b0, 1'b1, 1'b1, 1'b1, 13'd2, 32'h00FF0000, 32'h00AB0000, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0};
    vecs[2]  = '{mkRd(BASE+32'h8, 4'hF),            idlePort,                           1'b1, 1'b0, 1'b1, 1'b0, 13'd2,    32'hFFFFFFFF, 32'h0,        1'b1, 1'b0, 32'h11AB3344, 1'b0, 1'b0, 32'h0};
    vecs[3]  = '{mkRd(BASE+32'h8000, 4'hF),         idlePort,                           1'b1, 1'b0, 1'b0, 1'b0, 13'd0,    32'h0,        32'h0,        1'b1, 1'b1, 32'h0,        1'b0, 1'b0, 32'h0};
    vecs[4]  = '{idlePort,                           mkWr(BASE+32'h4, 4'h0, 32'h12345678), 1'b0, 1'b1, 1'b0, 1'b0, 13'd0, 32'h0,      32'h0,        1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0};
    vecs[5]  = '{mkRd(BASE+32'hC, 4'hF),            mkRd(BASE+32'h8, 4'hF),             1'b1, 1'b0, 1'b1, 1'b0, 13'd3,    32'hFFFFFFFF, 32'h0,        1'b1, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0};
    vecs[6]  = '{mkRd(BASE+32'hC, 4'hF),            mkRd(BASE+32'h8, 4'hF),             1'b0, 1'b1, 1'b1, 1'b0, 13'd2,    32'hFFFFFFFF, 32'h0,        1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h11AB3344};
    vecs[7]  = '{idlePort,                           mkRd(BASE-32'h4, 4'hF),             1'b0, 1'b1, 1'b0, 1'b0, 13'd0,    32'h0,        32'h0,        1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0};
    vecs[8]  = '{mkWr(BASE+32'h1C, 4'b1001, 32'hA5000055), idlePort,                    1'b1, 1'b0, 1'b1, 1'b1, 13'd7,    32'hFF0000FF, 32'hA5000055, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0};
    vecs[9]  = '{mkRd(BASE+32'h1C, 4'hF),           idlePort,                           1'b1, 1'b0, 1'b1, 1'b0, 13'd7,    32'hFFFFFFFF, 32'h0,        1'b1, 1'b0, 32'hA5000055, 1'b0, 1'b0, 32'h0};
    vecs[10] = '{idlePort,                           mkRd(BASE+32'h7FFC, 4'hF),          1'b0, 1'b1, 1'b1, 1'b0, 13'h1FFF, 32'hFFFFFFFF, 32'h0,        1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'hCAFEF00D};
    vecs[11] = '{idlePort,                           idlePort,                           1'b0, 1'b0, 1'b0, 1'b0, 13'd0,    32'h0,        32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0};

    // Reset state with both ports requesting: nothing granted, nothing returned.
    HRESETn = 1'b0;
    drivePorts(mkRd(BASE, 4'hF), mkRd(BASE, 4'hF));
    #1;
    checkOutput("reset gnt0", 32'(p0_gnt), 32'h0);
    checkOutput("reset gnt1", 32'(p1_gnt), 32'h0);
    checkOutput("reset ram_cs", 32'(ram_cs), 32'h0);
    checkOutput("reset rvalid0", 32'(p0_rvalid), 32'h0);
    checkOutput("reset rvalid1", 32'(p1_rvalid), 32'h0);
    checkOutput("reset rdata0", p0_rdata, 32'h0);
    checkOutput("reset rdata1", p1_rdata, 32'h0);
    drivePorts(idlePort, idlePort);
    @(negedge HCLK);
    @(negedge HCLK);
    HRESETn = 1'b1;

    for (int i = 0; i < NVEC; i++) applyStimulus(vecs[i], i);

    // Continuous contention: alternating grants, responses one cycle behind on the right port.
    for (int i = 0; i < 5; i++) begin
      @(negedge HCLK);
      if (i < 4) drivePorts(mkRd(BASE+32'hC, 4'hF), mkRd(BASE+32'h8, 4'hF));
      else drivePorts(idlePort, idlePort);
      #1;
      if (i < 4) begin
        checkOutput($sformatf("cont%0d gnt0", i), 32'(p0_gnt), 32'((i % 2) == 0));
        checkOutput($sformatf("cont%0d gnt1", i), 32'(p1_gnt), 32'((i % 2) == 1));
      end
      if (i > 0) begin
        checkOutput($sformatf("cont%0d rvalid0", i), 32'(p0_rvalid), 32'((i % 2) == 1));
        checkOutput($sformatf("cont%0d rvalid1", i), 32'(p1_rvalid), 32'((i % 2) == 0));
        checkOutput($sformatf("cont%0d rdata0", i), p0_rdata, ((i % 2) == 1) ? 32'hDEADBEEF : 32'h0);
        checkOutput($sformatf("cont%0d rdata1", i), p1_rdata, ((i % 2) == 0) ? 32'h11AB3344 : 32'h0);
      end
    end

    // Reset before the accepting edge: the grant disappears and no response follows.
    @(negedge HCLK);
    drivePorts(mkRd(BASE+32'hC, 4'hF), idlePort);
    #1;
    checkOutput("rstA gnt0 before", 32'(p0_gnt), 32'h1);
    #2;
    HRESETn = 1'b0;
    #1;
    checkOutput("rstA gnt0 in reset", 32'(p0_gnt), 32'h0);
    checkOutput("rstA ram_cs in reset", 32'(ram_cs), 32'h0);
    @(negedge HCLK);
    drivePorts(idlePort, idlePort);
    #1;
    checkOutput("rstA rvalid0", 32'(p0_rvalid), 32'h0);
    HRESETn = 1'b1;

    // Reset during the response cycle clears rvalid immediately.
    @(negedge HCLK);
    drivePorts(mkRd(BASE+32'hC, 4'hF), idlePort);
    @(posedge HCLK);
    #1;
    drivePorts(idlePort, idlePort);
    checkOutput("rstB rvalid0 before", 32'(p0_rvalid), 32'h1);
    checkOutput("rstB rdata0 before", p0_rdata, 32'hDEADBEEF);
    HRESETn = 1'b0;
    #1;
    checkOutput("rstB rvalid0 in reset", 32'(p0_rvalid), 32'h0);
    checkOutput("rstB rdata0 in reset", p0_rdata, 32'h0);
    @(negedge HCLK);
    HRESETn = 1'b1;

    // After reset the first tie goes to port 0 even though port 0 won last.
    @(negedge HCLK);
    drivePorts(mkRd(BASE+32'hC, 4'hF), mkRd(BASE+32'h8, 4'hF));
    #1;
    checkOutput("tie gnt0", 32'(p0_gnt), 32'h1);
    checkOutput("tie gnt1", 32'(p1_gnt), 32'h0);
    @(negedge HCLK);
    drivePorts(idlePort, idlePort);
    #1;
    checkOutput("tie rvalid0", 32'(p0_rvalid), 32'h1);
    checkOutput("tie rdata0", p0_rdata, 32'hDEADBEEF);
    checkOutput("tie rvalid1", 32'(p1_rvalid), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
